multicycle_ctrl: RTL

Multi-cycle control unit for the project's single-ported-memory MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. Every cycle it drives the datapath mux selects, the write enables and the 3-bit ALU operation code. It sits beside the datapath, reads the opcode field of the instruction register, and stalls on a memory-ready handshake.

---
 rtl/multicycle_ctrl_if.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller and the MIPS datapath.
// master : controller view (reads opcode and memory-ready, drives all controls)
// slave  : datapath view (drives opcode and memory-ready, reads all controls)
// Signals: instr_op_i, mem_ready_i (datapath -> ctrl); pc/ir/memory/regfile/
// ALU controls, state_o, retire_o, retire_cnt_o, illegal_o (ctrl -> datapath).
interface multicycle_ctrl_if;
  logic [5:0]  instr_op_i;
  logic        mem_ready_i;
  logic        pc_write_o;
  logic        pc_write_cond_o;
  logic [1:0]  pc_source_o;
  logic        ir_write_o;
  logic        i_or_d_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        mem_to_reg_o;
  logic        reg_dst_o;
  logic        reg_write_o;
  logic        alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [2:0]  alu_op_o;
  logic [3:0]  state_o;
  logic        retire_o;
  logic [15:0] retire_cnt_o;
  logic        illegal_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, i_or_d_o,
           mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, retire_o,
           retire_cnt_o, illegal_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, i_or_d_o,
           mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, retire_o,
           retire_cnt_o, illegal_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects, write enables and ALU op, and stalls
// on the memory-ready handshake. Halts on an illegal opcode until reset.
// Ports: clk_i (rising edge), rst_i (async, active-high),
//        bus (multicycle_ctrl_if.master) carrying all datapath controls.
// Parameter JUMP_EN: 1 makes opcode 000010 (j) legal, 0 makes it illegal.
module multicycle_ctrl #(
  parameter bit JUMP_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_EXI   = 4'd8,
    S_WBI   = 4'd9,
    S_BR    = 4'd10,
    S_JMP   = 4'd11,
    S_HALT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      state, state_next;
  logic [15:0] retire_cnt;

  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retire, illegal;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IF;
      retire_cnt <= '0;
    end else begin
      state <= state_next;
      if (retire) retire_cnt <= retire_cnt + 16'd1;
    end
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    retire        = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready_i;
        pc_write  = bus.mem_ready_i;
        if (bus.mem_ready_i) state_next = S_ID;
      end
      S_ID: begin
        alu_src_b = 2'b11;
        case (bus.instr_op_i)
          OP_RTYPE:       state_next = S_EXR;
          OP_LW, OP_SW:   state_next = S_MADDR;
          OP_BEQ:         state_next = S_BR;
          OP_ADDI, OP_SLTI: state_next = S_EXI;
          OP_J:           state_next = JUMP_EN ? S_JMP : S_HALT;
          default:        state_next = S_HALT;
        endcase
      end
      S_MADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        // Only lw/sw reach here, so anything that is not sw is a load.
        state_next = (bus.instr_op_i == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready_i) state_next = S_MWB;
      end
      S_MWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_IF;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready_i) begin
          retire     = 1'b1;
          state_next = S_IF;
        end
      end
      S_EXR: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b010;
        state_next = S_WBR;
      end
      S_WBR: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_IF;
      end
      S_EXI: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = (bus.instr_op_i == OP_SLTI) ? 3'b011 : 3'b000;
        state_next = S_WBI;
      end
      S_WBI: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_IF;
      end
      S_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_next    = S_IF;
      end
      S_JMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        retire     = 1'b1;
        state_next = S_IF;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: state_next = S_HALT;
    endcase
  end

  // Reset forces every output low combinationally, so an asynchronous reset
  // clears the bus before the next clock edge.
  assign bus.pc_write_o      = pc_write & ~rst_i;
  assign bus.pc_write_cond_o = pc_write_cond & ~rst_i;
  assign bus.pc_source_o     = rst_i ? '0 : pc_source;
  assign bus.ir_write_o      = ir_write & ~rst_i;
  assign bus.i_or_d_o        = i_or_d & ~rst_i;
  assign bus.mem_read_o      = mem_read & ~rst_i;
  assign bus.mem_write_o     = mem_write & ~rst_i;
  assign bus.mem_to_reg_o    = mem_to_reg & ~rst_i;
  assign bus.reg_dst_o       = reg_dst & ~rst_i;
  assign bus.reg_write_o     = reg_write & ~rst_i;
  assign bus.alu_src_a_o     = alu_src_a & ~rst_i;
  assign bus.alu_src_b_o     = rst_i ? '0 : alu_src_b;
  assign bus.alu_op_o        = rst_i ? '0 : alu_op;
  assign bus.state_o         = rst_i ? '0 : state;
  assign bus.retire_o        = retire & ~rst_i;
  assign bus.retire_cnt_o    = rst_i ? '0 : retire_cnt;
  assign bus.illegal_o       = illegal & ~rst_i;

endmodule
